// File: rtl/systolic_operand_loader.sv
// Operand loader for the 3x3 systolic array: collects an 18-word A/B frame into a
// shadow buffer, commits the skewed vectors, then sequences the array through one run.
module systolic_operand_loader #(
    parameter int DATA_W  = 16,
    parameter int N       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic [2*N-2:0][DATA_W-1:0]       west_0,
    output logic [2*N-2:0][DATA_W-1:0]       west_1,
    output logic [2*N-2:0][DATA_W-1:0]       west_2,
    output logic [2*N-2:0][DATA_W-1:0]       north_0,
    output logic [2*N-2:0][DATA_W-1:0]       north_1,
    output logic [2*N-2:0][DATA_W-1:0]       north_2,
    output logic                             arr_rst,
    input  logic                             arr_done,
    output logic                             busy,
    output logic                             mat_done,
    output logic                             err
);

    // state  | meaning
    // IDLE   | array held in reset, waiting for a full shadow frame
    // COMMIT | skewed shadow copied to west/north, shadow released for the next frame
    // RUN    | array released, waiting for arr_done or timeout
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int D     = 2 * N - 1;
    localparam int FRAME = 2 * N * N;
    localparam int CW    = $clog2(FRAME);
    localparam int TW    = $clog2(TIMEOUT);

    state_t state, state_nxt;

    logic [DATA_W-1:0] shadow [FRAME];
    logic [CW-1:0]     count;
    logic              shadow_full;
    logic              full_nxt;
    logic              xfer;
    logic              commit;
    logic              timeout_hit;
    logic [TW-1:0]     timer;

    logic [N-1:0][D-1:0][DATA_W-1:0] skew_w;
    logic [N-1:0][D-1:0][DATA_W-1:0] skew_n;

    assign xfer = in_valid & in_ready;

    always_comb begin
        state_nxt   = state;
        arr_rst     = 1'b1;
        busy        = 1'b0;
        mat_done    = 1'b0;
        commit      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (shadow_full)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                busy      = 1'b1;
                commit    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                arr_rst = 1'b0;
                // arr_done takes priority over a coincident timeout
                if (arr_done) begin
                    mat_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (timeout_hit)
                err <= 1'b1;
        end
    end

    always_comb begin
        full_nxt = shadow_full;
        if (commit)
            full_nxt = 1'b0;
        if (xfer && count == CW'(FRAME - 1))
            full_nxt = 1'b1;
    end

    // Shadow keeps loading in every state; the commit copy reads pre-write contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < FRAME; k++)
                shadow[k] <= '0;
            count       <= '0;
            shadow_full <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            shadow_full <= full_nxt;
            in_ready    <= !full_nxt;
            if (xfer) begin
                shadow[count] <= in_data;
                if (count == CW'(FRAME - 1))
                    count <= '0;
                else
                    count <= count + 1'b1;
            end
        end
    end

    // Row i of A enters west_i delayed by i; column j of B enters north_j delayed by j.
    always_comb begin
        skew_w = '0;
        skew_n = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                skew_w[i][i+j] = shadow[i*N+j];
                skew_n[j][i+j] = shadow[N*N+i*N+j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            west_0  <= '0;
            west_1  <= '0;
            west_2  <= '0;
            north_0 <= '0;
            north_1 <= '0;
            north_2 <= '0;
        end else if (commit) begin
            west_0  <= skew_w[0];
            west_1  <= skew_w[1];
            west_2  <= skew_w[2];
            north_0 <= skew_n[0];
            north_1 <= skew_n[1];
            north_2 <= skew_n[2];
        end
    end

endmodule
